// File: rtl/alu_pkg.sv
// Shared types and constants for the pipelined ALU: opcode encoding and the
// per-result flag bundle that travels alongside each result.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_INC  = 4'd2,
    OP_DEC  = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_NAND = 4'd6,
    OP_XOR  = 4'd7,
    OP_SHL  = 4'd8,
    OP_SHR  = 4'd9,
    OP_SRA  = 4'd10,
    OP_SLT  = 4'd11
  } alu_op_e;

  typedef struct packed {
    logic carry;
    logic zero;
    logic overflow;
    logic illegal;
  } alu_flags_t;

  localparam int ALU_OP_LAST = 11;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: opcode plus two operands in, result plus flags out.
// Holds no state; the pipeline around it does all the registering.
module alu_core
  import alu_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int OPCODE_W = 4
) (
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  output logic [DATA_W-1:0]   result,
  output alu_flags_t          flags
);

  localparam int SH_W = $clog2(DATA_W);
  localparam logic [DATA_W-1:0] ALL_ONES = {DATA_W{1'b1}};
  localparam logic [DATA_W-1:0] MAX_POS  = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MIN_NEG  = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W:0]   ONE_EXT  = {{DATA_W{1'b0}}, 1'b1};

  logic [SH_W-1:0]    amt;
  logic [DATA_W:0]    sum_w;
  logic [DATA_W:0]    diff_w;
  logic [DATA_W:0]    inc_w;
  logic [DATA_W:0]    dec_w;
  logic [DATA_W:0]    shl_w;
  logic [DATA_W:0]    shr_w;
  logic signed [DATA_W:0] sra_w;
  logic               carry;
  logic               overflow;
  logic               illegal;

  assign amt    = b[SH_W-1:0];
  assign sum_w  = {1'b0, a} + {1'b0, b};
  assign diff_w = {1'b0, a} - {1'b0, b};
  assign inc_w  = {1'b0, a} + ONE_EXT;
  assign dec_w  = {1'b0, a} - ONE_EXT;
  // Shifts run through one extra guard bit so the last bit shifted out
  // lands in a fixed position; an amount of zero leaves the guard clear.
  assign shl_w  = {1'b0, a} << amt;
  assign shr_w  = {a, 1'b0} >> amt;
  assign sra_w  = $signed({a, 1'b0}) >>> amt;

  always_comb begin
    result   = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    illegal  = 1'b0;
    if (opcode > OPCODE_W'(ALU_OP_LAST)) begin
      illegal = 1'b1;
    end else begin
      case (alu_op_e'(opcode[3:0]))
        OP_ADD: begin
          result   = sum_w[DATA_W-1:0];
          carry    = sum_w[DATA_W];
          overflow = (a[DATA_W-1] == b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
        end
        OP_SUB: begin
          result   = diff_w[DATA_W-1:0];
          carry    = diff_w[DATA_W];
          overflow = (a[DATA_W-1] != b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
        end
        OP_INC: begin
          result   = inc_w[DATA_W-1:0];
          carry    = (a == ALL_ONES);
          overflow = (a == MAX_POS);
        end
        OP_DEC: begin
          result   = dec_w[DATA_W-1:0];
          carry    = (a == '0);
          overflow = (a == MIN_NEG);
        end
        OP_AND:  result = a & b;
        OP_OR:   result = a | b;
        OP_NAND: result = ~(a & b);
        OP_XOR:  result = a ^ b;
        OP_SHL: begin
          result = shl_w[DATA_W-1:0];
          carry  = shl_w[DATA_W];
        end
        OP_SHR: begin
          result = shr_w[DATA_W:1];
          carry  = shr_w[0];
        end
        OP_SRA: begin
          result = sra_w[DATA_W:1];
          carry  = sra_w[0];
        end
        OP_SLT:  result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
        default: illegal = 1'b1;
      endcase
    end
  end

  assign flags.carry    = carry;
  assign flags.zero     = (result == '0);
  assign flags.overflow = overflow;
  assign flags.illegal  = illegal;

endmodule

// File: rtl/alu_pipe.sv
// Elastic valid/ready pipeline around alu_core: STAGES result registers with
// a fully combinational ready chain, so a full pipe can accept and drain together.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int OPCODE_W = 4,
  parameter int STAGES   = 2
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OPCODE_W-1:0] in_opcode,
  input  logic [DATA_W-1:0]   in_op1,
  input  logic [DATA_W-1:0]   in_op2,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_result,
  output logic                out_carry,
  output logic                out_zero,
  output logic                out_overflow,
  output logic                out_illegal
);

  localparam int WORD_W = DATA_W + $bits(alu_flags_t);

  logic [DATA_W-1:0] core_result;
  alu_flags_t        core_flags;
  alu_flags_t        out_flags;

  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] ld;
  logic [STAGES-1:0] src_vld;
  logic [WORD_W-1:0] data_q   [STAGES];
  logic [WORD_W-1:0] src_data [STAGES];

  alu_core #(
    .DATA_W   (DATA_W),
    .OPCODE_W (OPCODE_W)
  ) u_core (
    .opcode (in_opcode),
    .a      (in_op1),
    .b      (in_op2),
    .result (core_result),
    .flags  (core_flags)
  );

  // Stage k is blocked only when it and every stage after it are full and the
  // consumer is stalling; written flat to keep the chain free of feedback.
  always_comb begin
    ld = '0;
    for (int k = 0; k < STAGES; k++) begin
      logic blocked;
      blocked = !out_ready;
      for (int j = 0; j < STAGES; j++) begin
        if (j >= k) blocked = blocked & vld_q[j];
      end
      ld[k] = !blocked;
    end
  end

  always_comb begin
    src_vld     = '0;
    src_vld[0]  = in_valid;
    src_data[0] = {core_result, core_flags};
    for (int k = 1; k < STAGES; k++) begin
      src_vld[k]  = vld_q[k-1];
      src_data[k] = data_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_q <= '0;
      for (int k = 0; k < STAGES; k++) data_q[k] <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (ld[k]) begin
          vld_q[k] <= src_vld[k];
          if (src_vld[k]) data_q[k] <= src_data[k];
        end
      end
    end
  end

  assign in_ready                = ld[0];
  assign out_valid               = vld_q[STAGES-1];
  assign {out_result, out_flags} = data_q[STAGES-1];
  assign out_carry               = out_flags.carry;
  assign out_zero                = out_flags.zero;
  assign out_overflow            = out_flags.overflow;
  assign out_illegal             = out_flags.illegal;

endmodule
